// File: rtl/uart_programmer_pkg.sv
// ---- uart_programmer_pkg : record layout constants and UART FSM states (rev 1.0) ----
`default_nettype none

package uart_programmer_pkg;

  localparam int UPG_REC_BYTES   = 6;
  localparam int UPG_END_BIT     = 15;
  localparam int UPG_MEM_SEL_BIT = 14;

  typedef enum logic [1:0] {
    UART_ST_IDLE  = 2'd0,
    UART_ST_START = 2'd1,
    UART_ST_DATA  = 2'd2,
    UART_ST_STOP  = 2'd3
  } uart_st_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ---- uart_rx_byte : synchronised 8N1 receiver with glitch reject and framing check (rev 1.0) ----
`default_nettype none

module uart_rx_byte
  import uart_programmer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err,
  output logic       o_idle
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync3;
  uart_st_e      r_state;
  uart_st_e      w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_rx;
  logic          w_fall;
  logic          w_cnt_end;

  // r_sync3 only exists to detect the falling edge of the synchronised line.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rx      = r_sync2;
  assign w_fall    = r_sync3 & ~r_sync2;
  assign w_cnt_end = (r_state == UART_ST_START) ? (r_cnt == C_HALF_END) : (r_cnt == C_BIT_END);

  always_comb begin
    w_state_nxt  = r_state;
    o_byte_valid = 1'b0;
    o_frame_err  = 1'b0;
    case (r_state)
      UART_ST_IDLE: begin
        if (w_fall) w_state_nxt = UART_ST_START;
      end
      UART_ST_START: begin
        if (w_cnt_end) w_state_nxt = w_rx ? UART_ST_IDLE : UART_ST_DATA;
      end
      UART_ST_DATA: begin
        if (w_cnt_end && (r_bit == 3'd7)) w_state_nxt = UART_ST_STOP;
      end
      UART_ST_STOP: begin
        if (w_cnt_end) begin
          o_byte_valid = w_rx;
          o_frame_err  = ~w_rx;
          w_state_nxt  = UART_ST_IDLE;
        end
      end
      default: w_state_nxt = UART_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= UART_ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == UART_ST_IDLE) || w_cnt_end) r_cnt <= '0;
      else                                        r_cnt <= r_cnt + 1'b1;
      if (r_state != UART_ST_DATA) r_bit <= 3'd0;
      else if (w_cnt_end)          r_bit <= r_bit + 3'd1;
      if ((r_state == UART_ST_DATA) && w_cnt_end) r_shift <= {w_rx, r_shift[7:1]};
    end
  end

  assign o_byte = r_shift;
  assign o_idle = (r_state == UART_ST_IDLE);

endmodule

`default_nettype wire

// File: rtl/uart_programmer.sv
// ---- uart_programmer : UART boot loader driving the upg_* memory write port, acks end record (rev 1.0) ----
`default_nettype none

module uart_programmer
  import uart_programmer_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         TIMEOUT_BITS = 64,
  parameter logic [7:0] ACK_BYTE     = 8'h4B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        upg_err_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = $clog2(TIMEOUT_BITS + 1);
  localparam logic [CW-1:0] C_BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] C_TIMEOUT  = TW'(TIMEOUT_BITS);
  localparam logic [2:0]    C_LAST_IDX = 3'(UPG_REC_BYTES - 1);

  logic          w_byte_valid;
  logic [7:0]    w_byte;
  logic          w_frame_err;
  logic          w_rx_idle;

  logic [2:0]    r_idx;
  logic [15:0]   r_addr;
  logic [23:0]   r_data;
  logic          r_wen;
  logic [14:0]   r_adr;
  logic [31:0]   r_dat;
  logic          r_done;
  logic          r_done_d;
  logic          r_err;
  logic [CW-1:0] r_to_cnt;
  logic [TW-1:0] r_to_bits;
  logic          w_timeout;

  uart_st_e      r_tx_state;
  uart_st_e      w_tx_state_nxt;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic          r_tx;
  logic          w_tx_line;
  logic          w_tx_cnt_end;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .i_rst_n     (rst),
    .i_rx        (rx),
    .o_byte_valid(w_byte_valid),
    .o_byte      (w_byte),
    .o_frame_err (w_frame_err),
    .o_idle      (w_rx_idle)
  );

  assign w_timeout = (r_to_bits == C_TIMEOUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx  <= 3'd0;
      r_addr <= 16'd0;
      r_data <= 24'd0;
      r_wen  <= 1'b0;
      r_adr  <= 15'd0;
      r_dat  <= 32'd0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_wen <= 1'b0;
      if (w_frame_err) begin
        r_err <= 1'b1;
        r_idx <= 3'd0;
      end else if (w_byte_valid && !r_done) begin
        case (r_idx)
          3'd0:    r_addr[7:0]   <= w_byte;
          3'd1:    r_addr[15:8]  <= w_byte;
          3'd2:    r_data[7:0]   <= w_byte;
          3'd3:    r_data[15:8]  <= w_byte;
          3'd4:    r_data[23:16] <= w_byte;
          default: ;
        endcase
        if (r_idx == C_LAST_IDX) begin
          r_idx <= 3'd0;
          if (r_addr[UPG_END_BIT]) begin
            r_done <= 1'b1;
          end else begin
            r_wen <= 1'b1;
            r_adr <= r_addr[UPG_MEM_SEL_BIT:0];
            r_dat <= {w_byte, r_data};
          end
        end else begin
          r_idx <= r_idx + 3'd1;
        end
      end else if (w_timeout) begin
        r_idx <= 3'd0;
      end
    end
  end

  // Idle bit-time counter; any receiver activity or an empty record keeps it cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt  <= '0;
      r_to_bits <= '0;
    end else if ((r_idx == 3'd0) || !w_rx_idle || r_done) begin
      r_to_cnt  <= '0;
      r_to_bits <= '0;
    end else if (!w_timeout) begin
      if (r_to_cnt == C_BIT_END) begin
        r_to_cnt  <= '0;
        r_to_bits <= r_to_bits + 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign w_tx_cnt_end = (r_tx_cnt == C_BIT_END);

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_line      = 1'b1;
    case (r_tx_state)
      UART_ST_IDLE: begin
        if (r_done && !r_done_d) w_tx_state_nxt = UART_ST_START;
      end
      UART_ST_START: begin
        w_tx_line = 1'b0;
        if (w_tx_cnt_end) w_tx_state_nxt = UART_ST_DATA;
      end
      UART_ST_DATA: begin
        w_tx_line = ACK_BYTE[r_tx_bit];
        if (w_tx_cnt_end && (r_tx_bit == 3'd7)) w_tx_state_nxt = UART_ST_STOP;
      end
      UART_ST_STOP: begin
        if (w_tx_cnt_end) w_tx_state_nxt = UART_ST_IDLE;
      end
      default: w_tx_state_nxt = UART_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= UART_ST_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= 3'd0;
      r_tx       <= 1'b1;
      r_done_d   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx       <= w_tx_line;
      r_done_d   <= r_done;
      if ((r_tx_state == UART_ST_IDLE) || w_tx_cnt_end) r_tx_cnt <= '0;
      else                                              r_tx_cnt <= r_tx_cnt + 1'b1;
      if (r_tx_state != UART_ST_DATA) r_tx_bit <= 3'd0;
      else if (w_tx_cnt_end)          r_tx_bit <= r_tx_bit + 3'd1;
    end
  end

  assign tx         = r_tx;
  assign upg_wen_o  = r_wen;
  assign upg_adr_o  = r_adr;
  assign upg_dat_o  = r_dat;
  assign upg_done_o = r_done;
  assign upg_err_o  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_programmer.sv
// ---- tb_uart_programmer : scoreboard bench for the UART boot loader (rev 1.0) ----
`default_nettype none

module tb_uart_programmer;

  localparam int CPB = 4;

  typedef struct packed {
    logic [14:0] adr;
    logic [31:0] dat;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic        tx;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        upg_err_o;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];
  logic tx_chk_done = 1'b0;
  int  tx_extra = 0;

  uart_programmer #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(64),
    .ACK_BYTE    (8'h4B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .tx        (tx),
    .upg_wen_o (upg_wen_o),
    .upg_adr_o (upg_adr_o),
    .upg_dat_o (upg_dat_o),
    .upg_done_o(upg_done_o),
    .upg_err_o (upg_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic bit_time();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_time();
    end
    rx = stop_bit;
    bit_time();
    rx = 1'b1;
    bit_time();
  endtask

  task automatic send_rec(input logic [15:0] a, input logic [31:0] d);
    send_byte(a[7:0], 1'b1);
    send_byte(a[15:8], 1'b1);
    send_byte(d[7:0], 1'b1);
    send_byte(d[15:8], 1'b1);
    send_byte(d[23:16], 1'b1);
    send_byte(d[31:24], 1'b1);
  endtask

  task automatic expect_wr(input logic [14:0] a, input logic [31:0] d);
    wr_t e;
    e.adr = a;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    repeat (3 * CPB) @(negedge clk);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx"},   64'(tx),         64'd1);
    chk({tag, "_wen"},  64'(upg_wen_o),  64'd0);
    chk({tag, "_adr"},  64'(upg_adr_o),  64'd0);
    chk({tag, "_dat"},  64'(upg_dat_o),  64'd0);
    chk({tag, "_done"}, 64'(upg_done_o), 64'd0);
    chk({tag, "_err"},  64'(upg_err_o),  64'd0);
  endtask

  // Write monitor: every strobe cycle consumes one scoreboard entry.
  always @(negedge clk) begin
    if (rst && upg_wen_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual adr=%h dat=%h required=no write", upg_adr_o, upg_dat_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_adr", 64'(upg_adr_o), 64'(e.adr));
        chk("wr_dat", 64'(upg_dat_o), 64'(e.dat));
      end
    end
  end

  always @(negedge clk) begin
    if (tx_chk_done && (tx === 1'b0)) tx_extra++;
  end

  // Ack frame checker: start, 0x4B LSB-first, stop.
  initial begin
    logic [9:0] exp_frame;
    int n;
    exp_frame = {1'b1, 8'h4B, 1'b0};
    n = 0;
    @(negedge clk);
    while ((tx !== 1'b0) && (n < 40000)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40000) begin
      total++;
      bad++;
      $display("FAIL tx_frame_start actual=none required=start bit");
    end else begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("tx_bit%0d", i), 64'(tx), 64'(exp_frame[i]));
        if (i < 9) bit_time();
      end
      repeat (CPB) @(negedge clk);
    end
    tx_chk_done = 1'b1;
  end

  initial begin
    int n;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst0");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    expect_wr(15'h0004, 32'hDEADBEEF);
    send_rec(16'h0004, 32'hDEADBEEF);
    drain("t1_pending");
    chk("t1_done", 64'(upg_done_o), 64'd0);
    chk("t1_err",  64'(upg_err_o),  64'd0);

    expect_wr(15'h4010, 32'h12345678);
    send_rec(16'h4010, 32'h12345678);
    drain("t2a_pending");
    expect_wr(15'h0000, 32'h00000001);
    send_rec(16'h0000, 32'h00000001);
    drain("t2b_pending");
    repeat (10) @(negedge clk);
    chk("t2_adr_hold", 64'(upg_adr_o), 64'h0);
    chk("t2_dat_hold", 64'(upg_dat_o), 64'h1);

    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_glitch_err", 64'(upg_err_o), 64'd0);
    expect_wr(15'h0123, 32'hCAFEF00D);
    send_rec(16'h0123, 32'hCAFEF00D);
    drain("t5a_pending");
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    repeat (66) bit_time();
    expect_wr(15'h2468, 32'h89ABCDEF);
    send_rec(16'h2468, 32'h89ABCDEF);
    drain("t5b_pending");
    chk("t5_err", 64'(upg_err_o), 64'd0);

    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b0);
    repeat (2) bit_time();
    chk("t4_err", 64'(upg_err_o), 64'd1);
    chk("t4_pending", 64'(exp_q.size()), 64'd0);
    expect_wr(15'h0200, 32'hA5A55A5A);
    send_rec(16'h0200, 32'hA5A55A5A);
    drain("t4_pending2");

    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h99, 1'b1);
    send_byte(8'h88, 1'b1);
    rx = 1'b0;
    bit_time();
    rx = 1'b1;
    bit_time();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outputs("t6_rst");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) bit_time();
    expect_wr(15'h0044, 32'h0BADF00D);
    send_rec(16'h0044, 32'h0BADF00D);
    drain("t6_pending");

    send_rec(16'hFFFF, 32'h00000000);
    drain("t3_pending");
    chk("t3_done", 64'(upg_done_o), 64'd1);
    send_rec(16'h0005, 32'h11111111);
    drain("t3_post_pending");
    chk("t3_done_sticky", 64'(upg_done_o), 64'd1);
    n = 0;
    while (!tx_chk_done && (n < 2000)) begin
      @(negedge clk);
      n++;
    end
    chk("t3_tx_checker_done", 64'(tx_chk_done), 64'd1);
    repeat (40) @(negedge clk);
    chk("t3_tx_single_frame", 64'(tx_extra), 64'd0);
    chk("t3_tx_idle", 64'(tx), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
